// File: rtl/temp_conv_pipe.sv
// Three-stage Celsius/Fahrenheit converter with valid/ready handshakes on both
// sides, per-request channel tags, range checking and a saturating error count.
module temp_conv_pipe #(
  parameter int W    = 8,
  parameter int CHN  = 4,
  parameter int CMAX = 100,
  localparam int CW  = (CHN > 1) ? $clog2(CHN) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_format,
  input  logic [W-1:0]  in_data,
  input  logic [CW-1:0] in_ch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_ch,
  output logic          out_err,
  output logic [15:0]   err_cnt,
  input  logic          err_clr
);

  localparam int FMAX = (9 * CMAX + 2) / 5 + 32;
  localparam int IW   = W + 4;
  localparam logic [IW-1:0] CMAX_X = IW'(CMAX);
  localparam logic [IW-1:0] FMAX_X = IW'(FMAX);
  localparam logic [IW-1:0] F0_X   = IW'(32);

  logic          run_q, run_d;
  logic          s1Valid_q, s1Valid_d;
  logic          s1Fmt_q, s1Fmt_d;
  logic [W-1:0]  s1Data_q, s1Data_d;
  logic [CW-1:0] s1Ch_q, s1Ch_d;
  logic          s1Err_q, s1Err_d;
  logic          s2Valid_q, s2Valid_d;
  logic          s2Fmt_q, s2Fmt_d;
  logic [IW-1:0] s2Num_q, s2Num_d;
  logic [CW-1:0] s2Ch_q, s2Ch_d;
  logic          s2Err_q, s2Err_d;
  logic          outValid_q, outValid_d;
  logic [W-1:0]  outData_q, outData_d;
  logic [CW-1:0] outCh_q, outCh_d;
  logic          outErr_q, outErr_d;
  logic [15:0]   errCnt_q, errCnt_d;

  logic          ld1, ld2, ld3, accept, inIllegal;
  logic [IW-1:0] inExt, s1Ext, s1Num;

  // Each stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    ld3 = !outValid_q || out_ready;
    ld2 = !s2Valid_q || ld3;
    ld1 = !s1Valid_q || ld2;
  end

  // run_q keeps the input closed until the first clock after reset releases.
  assign in_ready = run_q && ld1;
  assign accept   = in_valid && in_ready;

  assign inExt = IW'(in_data);
  assign s1Ext = IW'(s1Data_q);

  always_comb begin
    if (in_format) inIllegal = (inExt < F0_X) || (inExt > FMAX_X);
    else           inIllegal = inExt > CMAX_X;
  end

  // Numerator with the rounding bias folded in; illegal requests carry zero.
  always_comb begin
    if (s1Err_q)      s1Num = '0;
    else if (s1Fmt_q) s1Num = (s1Ext - F0_X) * IW'(5) + IW'(4);
    else              s1Num = s1Ext * IW'(9) + IW'(2);
  end

  always_comb begin
    run_d      = 1'b1;
    s1Valid_d  = s1Valid_q;
    s1Fmt_d    = s1Fmt_q;
    s1Data_d   = s1Data_q;
    s1Ch_d     = s1Ch_q;
    s1Err_d    = s1Err_q;
    s2Valid_d  = s2Valid_q;
    s2Fmt_d    = s2Fmt_q;
    s2Num_d    = s2Num_q;
    s2Ch_d     = s2Ch_q;
    s2Err_d    = s2Err_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    outErr_d   = outErr_q;
    if (ld1) begin
      s1Valid_d = accept;
      s1Fmt_d   = in_format;
      s1Data_d  = in_data;
      s1Ch_d    = in_ch;
      s1Err_d   = inIllegal;
    end
    if (ld2) begin
      s2Valid_d = s1Valid_q;
      s2Fmt_d   = s1Fmt_q;
      s2Num_d   = s1Num;
      s2Ch_d    = s1Ch_q;
      s2Err_d   = s1Err_q;
    end
    if (ld3) begin
      outValid_d = s2Valid_q;
      outData_d  = s2Err_q ? '0 :
                   W'(s2Fmt_q ? (s2Num_q / IW'(9)) : (s2Num_q / IW'(5) + F0_X));
      outCh_d    = s2Ch_q;
      outErr_d   = s2Err_q;
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_comb begin
    errCnt_d = errCnt_q;
    if (err_clr)
      errCnt_d = '0;
    else if (accept && inIllegal && (errCnt_q != 16'hFFFF))
      errCnt_d = errCnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      s1Valid_q  <= 1'b0;
      s1Fmt_q    <= 1'b0;
      s1Data_q   <= '0;
      s1Ch_q     <= '0;
      s1Err_q    <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Fmt_q    <= 1'b0;
      s2Num_q    <= '0;
      s2Ch_q     <= '0;
      s2Err_q    <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCh_q    <= '0;
      outErr_q   <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      run_q      <= run_d;
      s1Valid_q  <= s1Valid_d;
      s1Fmt_q    <= s1Fmt_d;
      s1Data_q   <= s1Data_d;
      s1Ch_q     <= s1Ch_d;
      s1Err_q    <= s1Err_d;
      s2Valid_q  <= s2Valid_d;
      s2Fmt_q    <= s2Fmt_d;
      s2Num_q    <= s2Num_d;
      s2Ch_q     <= s2Ch_d;
      s2Err_q    <= s2Err_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      outErr_q   <= outErr_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_ch    = outCh_q;
  assign out_err   = outErr_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_temp_conv_pipe.sv
// Scoreboard bench for temp_conv_pipe: expected results are queued as requests
// are driven and compared in order as results leave the pipeline.
module tb_temp_conv_pipe;

  localparam int W    = 8;
  localparam int CHN  = 4;
  localparam int CMAX = 100;
  localparam int CW   = 2;
  localparam int FMAX = (9 * CMAX + 2) / 5 + 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_format;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_ch;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ch;
  logic          out_err;
  logic [15:0]   err_cnt;
  logic          err_clr;

  typedef struct {
    logic [W-1:0]  data;
    logic          err;
    logic [CW-1:0] ch;
  } expT;

  expT expQ[$];
  int  acceptQ[$];
  int  checkCnt = 0;
  int  failCnt  = 0;
  int  cyc      = 0;
  bit  sbEnable = 1'b1;
  bit  latChk   = 1'b0;
  bit  stalledPrev = 1'b0;
  bit  sawReadyLow = 1'b0;
  bit  randDone    = 1'b0;
  logic [W-1:0]  heldData;
  logic [CW-1:0] heldCh;
  logic          heldErr;

  temp_conv_pipe #(.W(W), .CHN(CHN), .CMAX(CMAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_format (in_format),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: returns {err, data}.
  function automatic logic [W:0] model(input logic fmt, input logic [W-1:0] d);
    int v;
    v = int'(d);
    if (!fmt) begin
      if (v > CMAX) return {1'b1, W'(0)};
      return {1'b0, W'((9 * v + 2) / 5 + 32)};
    end
    if (v < 32 || v > FMAX) return {1'b1, W'(0)};
    return {1'b0, W'((5 * (v - 32) + 4) / 9)};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic applyStimulus(input logic fmt, input logic [W-1:0] d, input logic [CW-1:0] ch,
                               input logic [W-1:0] ed, input logic ee);
    expT e;
    int  waitCnt;
    e.data = ed;
    e.err  = ee;
    e.ch   = ch;
    expQ.push_back(e);
    in_valid  = 1'b1;
    in_format = fmt;
    in_data   = d;
    in_ch     = ch;
    waitCnt   = 0;
    @(negedge clk);
    while (!in_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyModel(input logic fmt, input logic [W-1:0] d, input logic [CW-1:0] ch);
    logic [W:0] r;
    r = model(fmt, d);
    applyStimulus(fmt, d, ch, r[W-1:0], r[W]);
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
  endtask

  // Output monitor: ordering, payload, latency and hold-under-stall.
  always @(negedge clk) begin
    expT e;
    int  a;
    if (!reset_n) begin
      stalledPrev = 1'b0;
    end else begin
      if (in_valid && !in_ready) sawReadyLow = 1'b1;
      if (in_valid && in_ready && sbEnable) acceptQ.push_back(cyc);
      if (stalledPrev) begin
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdData", 32'(out_data), 32'(heldData));
        checkOutput("holdCh", 32'(out_ch), 32'(heldCh));
        checkOutput("holdErr", 32'(out_err), 32'(heldErr));
      end
      stalledPrev = out_valid && !out_ready;
      heldData = out_data;
      heldCh   = out_ch;
      heldErr  = out_err;
      if (out_valid && out_ready && sbEnable) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOut", 32'(out_valid), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("outData", 32'(out_data), 32'(e.data));
          checkOutput("outErr", 32'(out_err), 32'(e.err));
          checkOutput("outCh", 32'(out_ch), 32'(e.ch));
          if (acceptQ.size() != 0) begin
            a = acceptQ.pop_front();
            if (latChk) checkOutput("latency", 32'(cyc - a), 32'd3);
          end
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_format = 1'b0;
    in_data   = '0;
    in_ch     = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutData", 32'(out_data), 32'd0);
    checkOutput("rstOutCh", 32'(out_ch), 32'd0);
    checkOutput("rstOutErr", 32'(out_err), 32'd0);
    checkOutput("rstErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyAfterReset", 32'(in_ready), 32'd1);

    $display("[TB] C->F sweep");
    latChk = 1'b1;
    applyStimulus(1'b0, 8'd0,   2'd0, 8'd32,  1'b0);
    applyStimulus(1'b0, 8'd37,  2'd1, 8'd99,  1'b0);
    applyStimulus(1'b0, 8'd100, 2'd2, 8'd212, 1'b0);
    waitDrain();

    $display("[TB] F->C sweep with out-of-range inputs");
    applyStimulus(1'b1, 8'd32,  2'd0, 8'd0,   1'b0);
    applyStimulus(1'b1, 8'd98,  2'd1, 8'd37,  1'b0);
    applyStimulus(1'b1, 8'd212, 2'd2, 8'd100, 1'b0);
    applyStimulus(1'b1, 8'd31,  2'd3, 8'd0,   1'b1);
    applyStimulus(1'b1, 8'd213, 2'd0, 8'd0,   1'b1);
    waitDrain();
    checkOutput("errCnt2", 32'(err_cnt), 32'd2);
    applyStimulus(1'b0, 8'd101, 2'd1, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd255, 2'd2, 8'd0, 1'b1);
    applyStimulus(1'b1, 8'd0,   2'd3, 8'd0, 1'b1);
    waitDrain();
    checkOutput("errCnt5", 32'(err_cnt), 32'd5);
    latChk = 1'b0;

    $display("[TB] mixed formats back-to-back");
    for (int i = 0; i < 16; i++)
      applyModel(1'(i % 2), W'($urandom_range(0, 255)), CW'($urandom_range(0, CHN - 1)));
    waitDrain();

    $display("[TB] backpressure");
    sawReadyLow = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyModel(1'b0, W'(i * 17), CW'(i % 4));
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("inReadyDropped", 32'(sawReadyLow), 32'd1);

    $display("[TB] random backpressure");
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++)
          applyModel(1'($urandom_range(0, 1)), W'($urandom_range(0, 230)), CW'($urandom_range(0, CHN - 1)));
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] error counter saturation and clear");
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checkOutput("errClr", 32'(err_cnt), 32'd0);
    sbEnable  = 1'b0;
    in_valid  = 1'b1;
    in_format = 1'b0;
    in_data   = W'(CMAX + 1);
    in_ch     = '0;
    begin
      int n;
      int guard;
      n = 0;
      guard = 0;
      while (n < 65534 && guard < 70000) begin
        @(negedge clk);
        if (in_ready) n++;
        guard++;
      end
      checkOutput("floodCount", 32'(n), 32'd65534);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    sbEnable = 1'b1;
    checkOutput("errCntPreload", 32'(err_cnt), 32'hFFFE);
    applyStimulus(1'b1, 8'd10,  2'd0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd150, 2'd1, 8'd0, 1'b1);
    applyStimulus(1'b1, 8'd250, 2'd2, 8'd0, 1'b1);
    waitDrain();
    checkOutput("errCntSat", 32'(err_cnt), 32'hFFFF);
    err_clr = 1'b1;
    applyStimulus(1'b0, 8'd200, 2'd3, 8'd0, 1'b1);
    err_clr = 1'b0;
    checkOutput("errClrPriority", 32'(err_cnt), 32'd0);
    waitDrain();

    $display("[TB] reset with requests in flight");
    out_ready = 1'b0;
    applyModel(1'b0, 8'd10,  2'd1);
    applyModel(1'b0, 8'd20,  2'd2);
    applyModel(1'b0, 8'd150, 2'd3);
    checkOutput("preRstErrCnt", 32'(err_cnt), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstOutData", 32'(out_data), 32'd0);
    checkOutput("midRstOutCh", 32'(out_ch), 32'd0);
    checkOutput("midRstOutErr", 32'(out_err), 32'd0);
    checkOutput("midRstErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd0);
    expQ.delete();
    acceptQ.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("noStaleValid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'd100, 2'd1, 8'd212, 1'b0);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, failCnt);
    $finish;
  end

endmodule
